// File: rtl/reg_display_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_display_scan_pkg
// Description : Shared types, constants and the hex-to-segment table used by
//               the four-digit register display scanner.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_display_scan_pkg;

  typedef logic [1:0] digit_idx_t;   // which of the four digits is lit
  typedef logic [3:0] nibble_t;      // one hex digit
  typedef logic [3:0] an_t;          // digit enables, active-low
  typedef logic [6:0] seg_t;         // segments {g,f,e,d,c,b,a}, active-low

  localparam digit_idx_t DIG0 = 2'd0;   // rightmost: reg1[3:0]
  localparam digit_idx_t DIG1 = 2'd1;   // reg1[7:4]
  localparam digit_idx_t DIG2 = 2'd2;   // reg0[3:0], carries the separator dot
  localparam digit_idx_t DIG3 = 2'd3;   // leftmost: reg0[7:4]

  localparam seg_t SEG_OFF = 7'h7F;
  localparam an_t  AN_OFF  = 4'hF;

  // Entry n holds the active-low segment pattern for hex digit n (entry 15 first).
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  // Active-low one-cold digit enable for a digit index.
  function automatic an_t digit_an(input digit_idx_t d);
    return ~(an_t'(1) << d);
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_display_scan_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_display_scan_if
// Description : Register values and blank control in, display pins out.
//               master = register-file side, slave = display scanner.
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_display_scan_if;
  import reg_display_scan_pkg::*;

  logic [7:0] reg0_val;
  logic [7:0] reg1_val;
  logic       blank;
  an_t        an;
  seg_t       seg;
  logic       dp;
  logic       frame_tick;

  modport master (
    output reg0_val, reg1_val, blank,
    input  an, seg, dp, frame_tick
  );

  modport slave (
    input  reg0_val, reg1_val, blank,
    output an, seg, dp, frame_tick
  );

endinterface
`default_nettype wire

// File: rtl/reg_display_scan_hex_to_7seg.sv
`default_nettype none
// ============================================================================
// Module      : hex_to_7seg
// Description : Combinational hex nibble to active-low seven-segment decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module hex_to_7seg
  import reg_display_scan_pkg::*;
(
  input  nibble_t nibble_i,
  output seg_t    seg_o
);

  assign seg_o = HEX_SEG[nibble_i];

endmodule
`default_nettype wire

// File: rtl/reg_display_scan.sv
`default_nettype none
// ============================================================================
// Module      : reg_display_scan
// Description : Time-multiplexed 4-digit seven-segment driver showing
//               reg0 . reg1 as hex. Register values are snapshotted once per
//               frame so all four digits of a frame are coherent.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_display_scan
  import reg_display_scan_pkg::*;
#(
  parameter  int DATA_W   = 8,
  parameter  int PRESCALE = 4,
  localparam int CNT_W    = ($clog2(PRESCALE) > 1) ? $clog2(PRESCALE) : 1
) (
  input  wire logic          clk,
  input  wire logic          rst,
  reg_display_scan_if.slave  disp_if
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  digit_idx_t        idx_q, idx_d;
  logic              started_q, started_d;
  logic [DATA_W-1:0] shadow0_q, shadow0_d;
  logic [DATA_W-1:0] shadow1_q, shadow1_d;
  an_t               an_q;
  seg_t              seg_q;
  logic              dp_q;
  logic              frame_tick_q;

  logic              tick;
  logic              frame_start;
  logic              show;
  nibble_t           nibble;
  seg_t              seg_dec;

  assign tick        = (cnt_q == CNT_LAST);
  assign cnt_d       = tick ? '0 : cnt_q + 1'b1;
  assign frame_start = tick && (idx_d == DIG0);
  // Once scanning has begun the outputs are refreshed every edge; the value only
  // changes on a tick or a blank transition, so the pins never glitch.
  assign show        = tick || started_q;

  // The first tick after reset lands on digit 0; later ticks step 0-1-2-3-0.
  always_comb begin
    idx_d     = idx_q;
    started_d = started_q;
    if (tick) begin
      started_d = 1'b1;
      idx_d     = started_q ? idx_q + 2'd1 : DIG0;
    end
  end

  // Frame-start snapshot; the freshly sampled value is used for digit 0 on the same edge.
  always_comb begin
    shadow0_d = frame_start ? disp_if.reg0_val : shadow0_q;
    shadow1_d = frame_start ? disp_if.reg1_val : shadow1_q;
  end

  // Pick the nibble for the digit that will be lit after this edge.
  always_comb begin
    case (idx_d)
      DIG0:    nibble = shadow1_d[3:0];
      DIG1:    nibble = shadow1_d[7:4];
      DIG2:    nibble = shadow0_d[3:0];
      default: nibble = shadow0_d[7:4];
    endcase
  end

  hex_to_7seg u_hex_to_7seg (
    .nibble_i (nibble),
    .seg_o    (seg_dec)
  );

  // Prescaler, digit index and frame snapshot registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      idx_q     <= DIG0;
      started_q <= 1'b0;
      shadow0_q <= '0;
      shadow1_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      started_q <= started_d;
      shadow0_q <= shadow0_d;
      shadow1_q <= shadow1_d;
    end
  end

  // Registered display pins; blank darkens enables and dot but leaves the scan running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      frame_tick_q <= frame_start;
      if (show) begin
        seg_q <= seg_dec;
        if (disp_if.blank) begin
          an_q <= AN_OFF;
          dp_q <= 1'b1;
        end else begin
          an_q <= digit_an(idx_d);
          dp_q <= (idx_d != DIG2);
        end
      end
    end
  end

  assign disp_if.an         = an_q;
  assign disp_if.seg        = seg_q;
  assign disp_if.dp         = dp_q;
  assign disp_if.frame_tick = frame_tick_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_display_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_display_scan
// Description : Self-checking bench for reg_display_scan (PRESCALE 4 and 1),
//               randomized stimulus against a frame/digit arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_display_scan;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_display_scan_if ifa ();
  reg_display_scan_if ifb ();

  reg_display_scan #(.DATA_W(8), .PRESCALE(4)) dut_a (.clk(clk), .rst(rst), .disp_if(ifa));
  reg_display_scan #(.DATA_W(8), .PRESCALE(1)) dut_b (.clk(clk), .rst(rst), .disp_if(ifb));

  int n_checks = 0;
  int n_errors = 0;
  int sel      = 0;     // 0 -> dut_a (PRESCALE 4), 1 -> dut_b (PRESCALE 1)
  int edge_n   = 0;     // posedges since reset release

  logic [7:0] h0 [0:1023];
  logic [7:0] h1 [0:1023];
  logic       hb [0:1023];
  logic [7:0] cur0, cur1;
  logic       curb;
  logic [6:0] tbl [16];

  logic [3:0] o_an;
  logic [6:0] o_seg;
  logic       o_dp, o_ft;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [7:0] r0, input logic [7:0] r1, input logic b);
    cur0 = r0; cur1 = r1; curb = b;
    if (sel == 0) begin
      ifa.reg0_val = r0; ifa.reg1_val = r1; ifa.blank = b;
    end else begin
      ifb.reg0_val = r0; ifb.reg1_val = r1; ifb.blank = b;
    end
  endtask

  task automatic sample();
    if (sel == 0) begin
      o_an = ifa.an; o_seg = ifa.seg; o_dp = ifa.dp; o_ft = ifa.frame_tick;
    end else begin
      o_an = ifb.an; o_seg = ifb.seg; o_dp = ifb.dp; o_ft = ifb.frame_tick;
    end
  endtask

  // Expected pins at edge n: tick t = n/P lights digit (t-1)%4 of the frame whose
  // first tick was at edge P*(4*floor((t-1)/4)+1), where the registers were sampled.
  task automatic model(input int n, output logic [3:0] an, output logic [6:0] seg,
                       output logic dp, output logic ft, output logic seg_chk);
    int p, t, d, fs;
    logic [7:0] v0, v1;
    logic [3:0] nib, onehot;
    p = (sel == 0) ? 4 : 1;
    if (n < p) begin
      an = 4'hF; seg = 7'h7F; dp = 1'b1; ft = 1'b0; seg_chk = 1'b1;
    end else begin
      t  = n / p;
      d  = (t - 1) % 4;
      fs = p * (4 * ((t - 1) / 4) + 1);
      v0 = h0[fs];
      v1 = h1[fs];
      case (d)
        0:       nib = v1[3:0];
        1:       nib = v1[7:4];
        2:       nib = v0[3:0];
        default: nib = v0[7:4];
      endcase
      seg     = tbl[nib];
      ft      = ((n % p) == 0) && (d == 0);
      onehot  = 4'b0001 << d;
      an      = hb[n] ? 4'hF : ~onehot;
      dp      = hb[n] ? 1'b1 : ((d == 2) ? 1'b0 : 1'b1);
      seg_chk = !hb[n];
    end
  endtask

  // Record the inputs present at the coming edge, clock it, compare with the model.
  task automatic step();
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp, e_ft, e_sc;
    edge_n++;
    h0[edge_n] = cur0; h1[edge_n] = cur1; hb[edge_n] = curb;
    @(posedge clk);
    #1;
    sample();
    model(edge_n, e_an, e_seg, e_dp, e_ft, e_sc);
    check($sformatf("p%0d an@%0d", sel, edge_n), 32'(o_an), 32'(e_an));
    check($sformatf("p%0d dp@%0d", sel, edge_n), 32'(o_dp), 32'(e_dp));
    check($sformatf("p%0d frame_tick@%0d", sel, edge_n), 32'(o_ft), 32'(e_ft));
    if (e_sc) check($sformatf("p%0d seg@%0d", sel, edge_n), 32'(o_seg), 32'(e_seg));
  endtask

  // Asynchronous reset mid-cycle, checked before any clock edge sees it.
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    sample();
    check("reset an", 32'(o_an), 32'hF);
    check("reset seg", 32'(o_seg), 32'h7F);
    check("reset dp", 32'(o_dp), 32'h1);
    check("reset frame_tick", 32'(o_ft), 32'h0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst    = 1'b0;
    edge_n = 0;
  endtask

  initial begin
    logic [3:0] a, b;
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    ifa.reg0_val = 8'h00; ifa.reg1_val = 8'h00; ifa.blank = 1'b0;
    ifb.reg0_val = 8'h00; ifb.reg1_val = 8'h00; ifb.blank = 1'b0;

    // PRESCALE=4: basic scan, then reg1 changes mid-frame (snapshot).
    sel = 0;
    do_reset();
    drive(8'hA5, 8'h3C, 1'b0);
    for (int e = 1; e <= 20; e++) begin
      if (e == 9) drive(8'hA5, 8'hFF, 1'b0);
      step();
      case (edge_n)
        3:  check("first digit not before edge 4", 32'(o_an), 32'hF);
        4:  begin check("e4 an", 32'(o_an), 32'hE); check("e4 seg C", 32'(o_seg), 32'h46);
                  check("e4 frame_tick", 32'(o_ft), 32'h1); end
        8:  begin check("e8 an", 32'(o_an), 32'hD); check("e8 seg 3", 32'(o_seg), 32'h30); end
        12: begin check("e12 an", 32'(o_an), 32'hB); check("e12 seg 5", 32'(o_seg), 32'h12);
                  check("e12 dp", 32'(o_dp), 32'h0); end
        16: begin check("e16 an", 32'(o_an), 32'h7); check("e16 seg A", 32'(o_seg), 32'h08); end
        20: begin check("e20 an", 32'(o_an), 32'hE); check("e20 seg F", 32'(o_seg), 32'h0E);
                  check("e20 frame_tick", 32'(o_ft), 32'h1); end
        default: ;
      endcase
    end

    // PRESCALE=4: blank over edges 10..18 while registers wander.
    do_reset();
    drive(8'($urandom), 8'($urandom), 1'b0);
    for (int e = 1; e <= 24; e++) begin
      drive(8'($urandom), 8'($urandom), (e >= 10 && e <= 18));
      step();
      if (edge_n == 19) check("unblank shows idx3", 32'(o_an), 32'h7);
      if (edge_n == 20) check("blank e20 frame_tick", 32'(o_ft), 32'h1);
    end

    // PRESCALE=4: reset while digit 2 is lit, then random traffic with sporadic blank.
    do_reset();
    drive(8'($urandom), 8'($urandom), 1'b0);
    for (int e = 1; e <= 13; e++) step();
    check("mid-frame at idx2", 32'(o_an), 32'hB);
    do_reset();
    drive(8'($urandom), 8'($urandom), 1'b0);
    for (int e = 1; e <= 80; e++) begin
      if ($urandom_range(0, 2) == 0) drive(8'($urandom), 8'($urandom), ($urandom_range(0, 5) == 0));
      else drive(cur0, cur1, ($urandom_range(0, 5) == 0));
      step();
      if (edge_n == 3) check("post-reset dark e3", 32'(o_an), 32'hF);
    end

    // PRESCALE=1: every hex code across four frames, then random traffic.
    sel = 1;
    do_reset();
    for (int e = 1; e <= 16; e++) begin
      if ((e - 1) % 4 == 0) begin
        a = 4'((e - 1));
        b = 4'((e - 1) + 2);
        drive({b + 4'd1, b}, {a + 4'd1, a}, 1'b0);
      end
      step();
      if (edge_n == 1) check("p1 first edge frame_tick", 32'(o_ft), 32'h1);
      if (edge_n == 13) check("p1 e13 seg digit C", 32'(o_seg), 32'h46);
    end
    for (int e = 1; e <= 48; e++) begin
      drive(8'($urandom), 8'($urandom), ($urandom_range(0, 7) == 0));
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
